// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM request arbiter.
package sdram_pkg;

    localparam int BANK_W = 2;
    localparam int ROW_W  = 12;
    localparam int COL_W  = 8;
    localparam int ADDR_W = BANK_W + ROW_W + COL_W;
    localparam int DATA_W = 16;

    localparam int DEF_REFRESH_INTERVAL = 780;
    localparam int DEF_TIMEOUT          = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_REFRESH
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector; remembers the last requester granted.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
    output logic       sel,
    output logic       any
);

    logic last_q, last_d;

    // Pick the requester not served last on a tie; otherwise whoever is asking.
    always_comb begin
        any    = |req;
        sel    = (&req) ? ~last_q : req[1];
        last_d = take ? sel : last_q;
    end

    // last_grant starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) last_q <= 1'b1;
        else       last_q <= last_d;
    end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Arbitrates two requesters onto one SDRAM controller and schedules refresh.
module sdram_req_arbiter
    import sdram_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    parameter int TIMEOUT          = DEF_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req1_valid,
    input  logic              req0_we,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req0_grant,
    output logic              req1_grant,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic [DATA_W-1:0] rsp1_rdata,
    input  logic              mc_ready,
    output logic              mc_we,
    output logic              mc_re,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [DATA_W-1:0] mc_data_in,
    input  logic [DATA_W-1:0] mc_data_out,
    input  logic              mc_data_out_valid,
    output logic              mc_refresh_req,
    input  logic              mc_refresh_ack,
    output logic              busy,
    output logic              refresh_overrun,
    output logic              timeout_err
);

    localparam int RC_W = $clog2(REFRESH_INTERVAL + 1);
    localparam int WC_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [RC_W-1:0]   rcnt_q, rcnt_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic              pend_q, pend_d, ovr_q, ovr_d, tmo_q, tmo_d;
    logic              own_q, own_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d, mc_addr_q, mc_addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, mc_din_q, mc_din_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [1:0]        gnt_q, gnt_d, rsp_q, rsp_d;
    logic              mc_we_q, mc_we_d, mc_re_q, mc_re_d;
    logic              rreq_q, rreq_d, busy_q, busy_d;
    logic              wrap, rfsh_clr, take, sel, any;

    assign take = (state_q == ST_IDLE) && !pend_q && mc_ready && any;

    rr_arbiter2 u_rr (
        .clock (clock),
        .reset (reset),
        .req   ({req1_valid, req0_valid}),
        .take  (take),
        .sel   (sel),
        .any   (any)
    );

    // Next-state and next-output logic; every port is a flop below.
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        tmo_d    = tmo_q;
        ovr_d    = ovr_q;
        own_d    = own_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mc_addr_d = mc_addr_q;
        mc_din_d = mc_din_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        rreq_d   = rreq_q;
        gnt_d    = 2'b00;
        rsp_d    = 2'b00;
        mc_we_d  = 1'b0;
        mc_re_d  = 1'b0;
        rfsh_clr = 1'b0;

        // Free-running refresh timer, independent of the FSM.
        wrap   = (rcnt_q == RC_W'(REFRESH_INTERVAL - 1));
        rcnt_d = wrap ? '0 : rcnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    state_d = ST_REFRESH;
                    rreq_d  = 1'b1;
                end else if (take) begin
                    gnt_d[sel] = 1'b1;
                    own_d      = sel;
                    we_d       = sel ? req1_we    : req0_we;
                    addr_d     = sel ? req1_addr  : req0_addr;
                    wdata_d    = sel ? req1_wdata : req0_wdata;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mc_we_d   = we_q;
                mc_re_d   = !we_q;
                mc_addr_d = addr_q;
                mc_din_d  = wdata_q;
                wcnt_d    = '0;
                state_d   = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                wcnt_d = wcnt_q + 1'b1;
                // Completion wins over a timeout landing in the same cycle.
                if (!we_q && mc_data_out_valid) begin
                    rsp_d[own_q] = 1'b1;
                    if (own_q) rdata1_d = mc_data_out;
                    else       rdata0_d = mc_data_out;
                    state_d = ST_IDLE;
                end else if (we_q && mc_ready && wcnt_q >= WC_W'(1)) begin
                    state_d = ST_IDLE;
                end else if (wcnt_q == WC_W'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_REFRESH: begin
                if (mc_refresh_ack) begin
                    rreq_d   = 1'b0;
                    rfsh_clr = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A wrap coinciding with the ack means a fresh refresh is already due.
        pend_d = wrap ? 1'b1 : (rfsh_clr ? 1'b0 : pend_q);
        if (wrap && pend_q && !rfsh_clr) ovr_d = 1'b1;

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rcnt_q    <= '0;
            wcnt_q    <= '0;
            pend_q    <= 1'b0;
            ovr_q     <= 1'b0;
            tmo_q     <= 1'b0;
            own_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mc_addr_q <= '0;
            mc_din_q  <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            gnt_q     <= 2'b00;
            rsp_q     <= 2'b00;
            mc_we_q   <= 1'b0;
            mc_re_q   <= 1'b0;
            rreq_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            wcnt_q    <= wcnt_d;
            pend_q    <= pend_d;
            ovr_q     <= ovr_d;
            tmo_q     <= tmo_d;
            own_q     <= own_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mc_addr_q <= mc_addr_d;
            mc_din_q  <= mc_din_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            gnt_q     <= gnt_d;
            rsp_q     <= rsp_d;
            mc_we_q   <= mc_we_d;
            mc_re_q   <= mc_re_d;
            rreq_q    <= rreq_d;
            busy_q    <= busy_d;
        end
    end

    assign req0_grant      = gnt_q[0];
    assign req1_grant      = gnt_q[1];
    assign rsp0_valid      = rsp_q[0];
    assign rsp1_valid      = rsp_q[1];
    assign rsp0_rdata      = rdata0_q;
    assign rsp1_rdata      = rdata1_q;
    assign mc_we           = mc_we_q;
    assign mc_re           = mc_re_q;
    assign mc_addr         = mc_addr_q;
    assign mc_data_in      = mc_din_q;
    assign mc_refresh_req  = rreq_q;
    assign busy            = busy_q;
    assign refresh_overrun = ovr_q;
    assign timeout_err     = tmo_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Scoreboard bench for sdram_req_arbiter (REFRESH_INTERVAL=20, TIMEOUT=8).
module tb_sdram_req_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_we = 1'b0, req1_we = 1'b0;
    logic [21:0] req0_addr = '0, req1_addr = '0;
    logic [15:0] req0_wdata = '0, req1_wdata = '0;
    logic        req0_grant, req1_grant, rsp0_valid, rsp1_valid;
    logic [15:0] rsp0_rdata, rsp1_rdata;
    logic        mc_ready = 1'b1;
    logic        mc_we, mc_re;
    logic [21:0] mc_addr;
    logic [15:0] mc_data_in;
    logic [15:0] mc_data_out = '0;
    logic        mc_data_out_valid = 1'b0;
    logic        mc_refresh_req;
    logic        mc_refresh_ack = 1'b0;
    logic        busy, refresh_overrun, timeout_err;

    always #5 clock = ~clock;

    sdram_req_arbiter #(.REFRESH_INTERVAL(20), .TIMEOUT(8)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_we(req0_we), .req1_we(req1_we),
        .req0_addr(req0_addr), .req1_addr(req1_addr),
        .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
        .req0_grant(req0_grant), .req1_grant(req1_grant),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_rdata(rsp0_rdata), .rsp1_rdata(rsp1_rdata),
        .mc_ready(mc_ready), .mc_we(mc_we), .mc_re(mc_re),
        .mc_addr(mc_addr), .mc_data_in(mc_data_in),
        .mc_data_out(mc_data_out), .mc_data_out_valid(mc_data_out_valid),
        .mc_refresh_req(mc_refresh_req), .mc_refresh_ack(mc_refresh_ack),
        .busy(busy), .refresh_overrun(refresh_overrun), .timeout_err(timeout_err)
    );

    logic [79:0] all_o;
    assign all_o = {req0_grant, req1_grant, rsp0_valid, rsp1_valid, mc_we, mc_re,
                    mc_refresh_req, busy, refresh_overrun, timeout_err,
                    rsp0_rdata, rsp1_rdata, mc_addr, mc_data_in};

    typedef struct { logic we; logic [21:0] addr; logic [15:0] data; } cmd_t;
    typedef struct { logic owner; logic [15:0] data; } rsp_t;

    cmd_t rq0[$], rq1[$];
    int   exp_gnt[$];
    cmd_t exp_cmd[$];
    rsp_t exp_rsp[$];

    int total = 0, bad = 0;
    logic        ack_en = 1'b1, rd_en = 1'b0, stray = 1'b0;
    logic [15:0] rd_data = '0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Requester models: present the head of each queue until it is granted.
    always @(negedge clock) begin
        if (req0_grant && rq0.size() > 0) void'(rq0.pop_front());
        if (req1_grant && rq1.size() > 0) void'(rq1.pop_front());
        if (rq0.size() > 0) begin
            req0_valid = 1'b1; req0_we = rq0[0].we; req0_addr = rq0[0].addr; req0_wdata = rq0[0].data;
        end else req0_valid = 1'b0;
        if (rq1.size() > 0) begin
            req1_valid = 1'b1; req1_we = rq1[0].we; req1_addr = rq1[0].addr; req1_wdata = rq1[0].data;
        end else req1_valid = 1'b0;
    end

    // Controller model: read data one cycle after mc_re, auto refresh ack.
    always @(negedge clock) begin
        mc_data_out_valid = (mc_re && rd_en) || stray;
        mc_data_out       = rd_data;
        mc_refresh_ack    = ack_en && mc_refresh_req;
    end

    // Monitor: pops the scoreboard whenever the DUT presents an output pulse.
    logic prev_gnt = 1'b0;
    int   eg;
    cmd_t ec;
    rsp_t er;
    always @(negedge clock) begin
        if (req0_grant || req1_grant) begin
            if (exp_gnt.size() == 0) chk("unexpected_grant", {req1_grant, req0_grant}, 0);
            else begin
                eg = exp_gnt.pop_front();
                chk("grant_owner", {req1_grant, req0_grant}, (eg == 0) ? 2'b01 : 2'b10);
            end
        end
        if (mc_we || mc_re) begin
            chk("cmd_latency", prev_gnt, 1);
            if (exp_cmd.size() == 0) chk("unexpected_cmd", {mc_we, mc_re}, 0);
            else begin
                ec = exp_cmd.pop_front();
                chk("cmd_we", mc_we, ec.we);
                chk("cmd_re", mc_re, !ec.we);
                chk("cmd_addr", mc_addr, ec.addr);
                if (ec.we) chk("cmd_wdata", mc_data_in, ec.data);
            end
        end
        if (rsp0_valid || rsp1_valid) begin
            if (exp_rsp.size() == 0) chk("unexpected_rsp", {rsp1_valid, rsp0_valid}, 0);
            else begin
                er = exp_rsp.pop_front();
                chk("rsp_owner", {rsp1_valid, rsp0_valid}, er.owner ? 2'b10 : 2'b01);
                chk("rsp_rdata", er.owner ? rsp1_rdata : rsp0_rdata, er.data);
            end
        end
        if (mc_refresh_req) chk("grant_during_refresh", req0_grant | req1_grant, 0);
        prev_gnt = req0_grant | req1_grant;
    end

    task automatic push_req(input int who, input logic we, input logic [21:0] a, input logic [15:0] d);
        cmd_t c;
        c.we = we; c.addr = a; c.data = d;
        if (who == 0) rq0.push_back(c); else rq1.push_back(c);
        exp_gnt.push_back(who);
        exp_cmd.push_back(c);
    endtask

    function automatic int outstanding();
        return exp_gnt.size() + exp_cmd.size() + exp_rsp.size() + rq0.size() + rq1.size();
    endfunction

    task automatic drain(input string nm, input int n);
        for (int i = 0; i < n; i++) begin
            if (outstanding() == 0) break;
            @(negedge clock);
        end
        repeat (4) @(negedge clock);
        chk(nm, outstanding(), 0);
    endtask

    // Holds reset, checks every output is 0, returns at a negedge with reset still high.
    task automatic reset_dut();
        reset = 1'b1; ack_en = 1'b1; rd_en = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_outputs", all_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rsp_t r;

        // Single read from requester 0.
        reset_dut();
        rd_en = 1'b1; rd_data = 16'hBEEF;
        push_req(0, 1'b0, 22'h012345, 16'h0000);
        r.owner = 1'b0; r.data = 16'hBEEF; exp_rsp.push_back(r);
        reset = 1'b0;
        drain("read_drain", 40);

        // Tie arbitration: four writes each, both valid from reset.
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            push_req(0, 1'b1, 22'h100000 + 22'(i), 16'hA000 + 16'(i));
            push_req(1, 1'b1, 22'h200000 + 22'(i), 16'hB000 + 16'(i));
        end
        reset = 1'b0;
        drain("tie_drain", 200);

        // Refresh priority: IDLE cycles at 0,4,..,20; wrap makes cycle 20's IDLE go to REFRESH.
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            push_req(0, 1'b1, 22'h0000F0 + 22'(i), 16'h1100 + 16'(i));
            push_req(1, 1'b1, 22'h0000E0 + 22'(i), 16'h2200 + 16'(i));
        end
        reset = 1'b0;
        repeat (20) @(negedge clock);
        chk("refresh_not_yet", mc_refresh_req, 0);
        @(negedge clock);
        chk("refresh_rise", mc_refresh_req, 1);
        chk("refresh_busy", busy, 1);
        @(negedge clock);
        chk("refresh_released", {mc_refresh_req, busy}, 2'b00);
        drain("refresh_drain", 100);

        // Overrun: no ack for two intervals; second wrap lands at cycle 40.
        reset_dut();
        ack_en = 1'b0;
        reset = 1'b0;
        repeat (39) @(negedge clock);
        chk("overrun_not_yet", refresh_overrun, 0);
        @(negedge clock);
        chk("overrun_set", refresh_overrun, 1);
        chk("overrun_req_held", mc_refresh_req, 1);
        ack_en = 1'b1;
        repeat (30) @(negedge clock);
        chk("overrun_sticky", refresh_overrun, 1);

        // Read timeout: grant at cycle 1, WAIT_DONE cycles 2..9, back in IDLE at 10.
        reset_dut();
        push_req(1, 1'b0, 22'h3ABCDE, 16'h0000);
        reset = 1'b0;
        repeat (9) @(negedge clock);
        chk("timeout_not_yet", {timeout_err, busy}, 2'b01);
        @(negedge clock);
        chk("timeout_set", {timeout_err, busy}, 2'b10);
        drain("timeout_drain", 30);

        // Reset during WAIT_DONE, then a late data strobe must not respond.
        reset_dut();
        push_req(0, 1'b0, 22'h2AAAAA, 16'h0000);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("midaccess_busy", busy, 1);
        reset = 1'b1;
        @(negedge clock);
        chk("midaccess_reset_outputs", all_o, 0);
        reset = 1'b0;
        @(posedge clock); #1 stray = 1'b1;
        @(posedge clock); #1 stray = 1'b0;
        drain("midaccess_drain", 10);
        chk("midaccess_idle", {busy, rsp0_valid, rsp1_valid}, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
